// File: rtl/uart_apb_bridge.sv
// APB3 slave bridging CPU accesses to the byte-level rs232 core (TX/RX FIFOs).
// Optional CTRL register and level interrupt enabled by UART_BRIDGE_IRQ_EN.
module uart_apb_bridge #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [7:0]  pi_data,
  output logic        pi_flag,
  input  logic        tx_busy,
  input  logic [7:0]  po_data,
  input  logic        po_flag,
  output logic        irq
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } tx_state_e;

  tx_state_e      state_q;
  logic [7:0]     pi_data_q;
  logic           pi_flag_q;
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [TAW:0]   tx_wp_q, tx_rp_q;
  logic [RAW:0]   rx_wp_q, rx_rp_q;
  logic           rx_ovr_q, tx_ovf_q;
  logic           rx_ovr_d, tx_ovf_d;
  logic [2:0]     ctrl_rd;

  logic acc, wr_acc, rd_acc;
  logic sel_data, sel_stat, sel_ctrl;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push_req, tx_push, tx_pop;
  logic rx_push, rx_pop, tx_active;
  logic [6:0] status;
  logic unused_ok;

  assign acc      = psel & penable;
  assign wr_acc   = acc & pwrite;
  assign rd_acc   = acc & ~pwrite;
  assign sel_data = (paddr[3:2] == 2'd0);
  assign sel_stat = (paddr[3:2] == 2'd1);
  assign sel_ctrl = (paddr[3:2] == 2'd2);

  assign tx_full  = (tx_wp_q[TAW] != tx_rp_q[TAW]) &&
                    (tx_wp_q[TAW-1:0] == tx_rp_q[TAW-1:0]);
  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign rx_full  = (rx_wp_q[RAW] != rx_rp_q[RAW]) &&
                    (rx_wp_q[RAW-1:0] == rx_rp_q[RAW-1:0]);
  assign rx_empty = (rx_wp_q == rx_rp_q);

  assign tx_push_req = wr_acc & sel_data;
  assign tx_push     = tx_push_req & ~tx_full;
  assign tx_pop      = (state_q == S_LAUNCH);
  assign rx_pop      = rd_acc & sel_data & ~rx_empty;
  // a pop in the same cycle frees the slot the incoming byte needs
  assign rx_push     = po_flag & (~rx_full | rx_pop);
  assign tx_active   = (state_q != S_IDLE) | tx_busy;

  assign status = {tx_active, tx_ovf_q, rx_ovr_q,
                   ~rx_empty, rx_full, tx_empty, tx_full};

  assign rx_ovr_d = (rx_ovr_q & ~(wr_acc & sel_stat & pwdata[4])) |
                    (po_flag & rx_full & ~rx_pop);
  assign tx_ovf_d = (tx_ovf_q & ~(wr_acc & sel_stat & pwdata[5])) |
                    (tx_push_req & tx_full);

  always_comb begin
    prdata = '0;
    if (rd_acc) begin
      unique case (1'b1)
        sel_data: prdata = rx_empty ? 32'h0 :
                           {24'h0, rx_mem[rx_rp_q[RAW-1:0]]};
        sel_stat: prdata = {25'h0, status};
        sel_ctrl: prdata = {29'h0, ctrl_rd};
        default:  prdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[TAW-1:0]] <= pwdata[7:0];
    if (rx_push) rx_mem[rx_wp_q[RAW-1:0]] <= po_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_ovr_q <= 1'b0;
      tx_ovf_q <= 1'b0;
    end else begin
      tx_wp_q  <= tx_wp_q + {{TAW{1'b0}}, tx_push};
      tx_rp_q  <= tx_rp_q + {{TAW{1'b0}}, tx_pop};
      rx_wp_q  <= rx_wp_q + {{RAW{1'b0}}, rx_push};
      rx_rp_q  <= rx_rp_q + {{RAW{1'b0}}, rx_pop};
      rx_ovr_q <= rx_ovr_d;
      tx_ovf_q <= tx_ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      pi_data_q <= 8'h0;
      pi_flag_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!tx_empty && !tx_busy) begin
            state_q   <= S_LAUNCH;
            pi_flag_q <= 1'b1;
            pi_data_q <= tx_mem[tx_rp_q[TAW-1:0]];
          end
        end
        S_LAUNCH: begin
          pi_flag_q <= 1'b0;
          state_q   <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: if (tx_busy) state_q <= S_WAIT_DONE;
        S_WAIT_DONE: if (!tx_busy) state_q <= S_IDLE;
        default: begin
          state_q   <= S_IDLE;
          pi_flag_q <= 1'b0;
        end
      endcase
    end
  end

  assign pi_data = pi_data_q;
  assign pi_flag = pi_flag_q;
  assign pready  = 1'b1;
  assign pslverr = 1'b0;

`ifdef UART_BRIDGE_IRQ_EN
  logic [2:0] ctrl_q;
  logic       irq_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_q <= 3'h0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_acc && sel_ctrl) ctrl_q <= pwdata[2:0];
      irq_q <= (ctrl_q[0] & ~rx_empty) |
               (ctrl_q[1] & tx_empty & (state_q == S_IDLE)) |
               (ctrl_q[2] & (rx_ovr_q | tx_ovf_q));
    end
  end

  assign ctrl_rd = ctrl_q;
  assign irq     = irq_q;
`else
  assign ctrl_rd = 3'h0;
  assign irq     = 1'b0;
`endif

  assign unused_ok = &{1'b0, paddr[1:0], pwdata[31:8]};

endmodule

// File: tb/tb_uart_apb_bridge.sv
// Self-checking bench for uart_apb_bridge: register vectors, directed
// corner sequences and randomized RX/TX traffic against a queue model.
module tb_uart_apb_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic        psel, penable, pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [7:0]  pi_data;
  logic        pi_flag;
  logic        tx_busy;
  logic [7:0]  po_data;
  logic        po_flag;
  logic        irq;

  uart_apb_bridge #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk(clk), .rstn(rstn),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr),
    .pi_data(pi_data), .pi_flag(pi_flag), .tx_busy(tx_busy),
    .po_data(po_data), .po_flag(po_flag), .irq(irq)
  );

  always #5 clk = ~clk;

`ifdef UART_BRIDGE_IRQ_EN
  localparam logic [31:0] CTRL_RB = 32'h7;
`else
  localparam logic [31:0] CTRL_RB = 32'h0;
`endif

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // transmitter model: busy for 10 cycles after each send strobe
  logic hold_busy = 1'b0;
  int   busy_cnt  = 0;
  always @(posedge clk) begin
    if (pi_flag) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = hold_busy | (busy_cnt != 0);

  int         cyc = 0;
  logic [7:0] seen_q[$];
  int         seen_cyc[$];
  logic       prev_flag = 1'b0;
  int         double_pulse = 0;
  int         irq_bad = 0;
  always @(negedge clk) begin
    cyc++;
    if (pi_flag) begin
      seen_q.push_back(pi_data);
      seen_cyc.push_back(cyc);
      if (prev_flag) double_pulse++;
    end
    prev_flag = pi_flag;
`ifndef UART_BRIDGE_IRQ_EN
    if (irq !== 1'b0) irq_bad++;
`endif
  end

  // reference model
  logic [7:0] rx_m[$];
  logic       rx_ovr_m = 1'b0;
  logic       tx_ovf_m = 1'b0;

  function automatic logic [31:0] exp_status_idle();
    logic [6:0] s;
    s = {1'b0, tx_ovf_m, rx_ovr_m, rx_m.size() > 0,
         rx_m.size() == 16, 1'b1, 1'b0};
    return {25'h0, s};
  endfunction

  task automatic apb(input logic wr, input logic [3:0] a,
                     input logic [31:0] wd, input logic push,
                     input logic [7:0] pd, output logic [31:0] rd);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(negedge clk);
    penable = 1'b1;
    if (push) begin po_flag = 1'b1; po_data = pd; end
    #1 rd = prdata;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; po_flag = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r;
    apb(1'b1, a, d, 1'b0, 8'h0, r);
  endtask

  task automatic rx_push(input logic [7:0] d);
    @(negedge clk);
    po_flag = 1'b1; po_data = d;
    @(posedge clk);
    #1 po_flag = 1'b0;
    if (rx_m.size() < 16) rx_m.push_back(d);
    else rx_ovr_m = 1'b1;
  endtask

  task automatic rd_data(input string name, input logic push,
                         input logic [7:0] pd);
    logic [31:0] r, e;
    apb(1'b0, 4'h0, 32'h0, push, pd, r);
    e = (rx_m.size() > 0) ? {24'h0, rx_m.pop_front()} : 32'h0;
    if (push) begin
      if (rx_m.size() < 16) rx_m.push_back(pd);
      else rx_ovr_m = 1'b1;
    end
    chk(name, r, e);
  endtask

  task automatic rd_stat(input string name, input logic [31:0] e);
    logic [31:0] r;
    apb(1'b0, 4'h4, 32'h0, 1'b0, 8'h0, r);
    chk(name, r, e);
  endtask

  task automatic wait_seen(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (seen_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, seen_q.size(), n);
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vt[11];

  initial begin
    logic [31:0] r;
    logic [7:0]  tx_exp[$];
    vt[0]  = '{1'b0, 4'h4, 32'h0, 32'h2, "vec_stat_rst"};
    vt[1]  = '{1'b0, 4'h0, 32'h0, 32'h0, "vec_data_empty"};
    vt[2]  = '{1'b0, 4'h8, 32'h0, 32'h0, "vec_ctrl_rst"};
    vt[3]  = '{1'b0, 4'hC, 32'h0, 32'h0, "vec_unmapped"};
    vt[4]  = '{1'b1, 4'hC, 32'hFFFFFFFF, 32'h0, "vec_wr_unmapped"};
    vt[5]  = '{1'b1, 4'h4, 32'hFFFFFFFF, 32'h0, "vec_wr_stat"};
    vt[6]  = '{1'b0, 4'h4, 32'h0, 32'h2, "vec_stat_after_wr"};
    vt[7]  = '{1'b1, 4'h8, 32'hFFFFFFFF, 32'h0, "vec_wr_ctrl"};
    vt[8]  = '{1'b0, 4'h8, 32'h0, CTRL_RB, "vec_ctrl_rb"};
    vt[9]  = '{1'b1, 4'h8, 32'h0, 32'h0, "vec_ctrl_clr"};
    vt[10] = '{1'b0, 4'h8, 32'h0, 32'h0, "vec_ctrl_zero"};

    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    po_data = 0; po_flag = 0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pi_flag", {31'h0, pi_flag}, 32'h0);
    chk("rst_pi_data", {24'h0, pi_data}, 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rstn = 1'b1;
    @(negedge clk);
    chk("pready", {31'h0, pready}, 32'h1);
    chk("pslverr", {31'h0, pslverr}, 32'h0);

    for (int i = 0; i < 11; i++) begin
      apb(vt[i].wr, vt[i].addr, vt[i].wdata, 1'b0, 8'h0, r);
      if (!vt[i].wr) chk(vt[i].name, r, vt[i].exp);
    end
    chk("prdata_idle", prdata, 32'h0);

    // two bytes paced by the transmitter model
    seen_q.delete(); seen_cyc.delete();
    wr(4'h0, 32'h41);
    wr(4'h0, 32'hFFFFFF42);
    wait_seen("t1_count", 2, 200);
    if (seen_q.size() == 2) begin
      chk("t1_byte0", {24'h0, seen_q[0]}, 32'h41);
      chk("t1_byte1", {24'h0, seen_q[1]}, 32'h42);
      chk("t1_spacing", {31'h0, (seen_cyc[1] - seen_cyc[0]) >= 13}, 32'h1);
    end
    repeat (20) @(negedge clk);
    rd_stat("t1_stat_idle", exp_status_idle());

    // single RX byte
    rx_push(8'h5A);
    rd_stat("t2_stat_valid", 32'h0A);
    rd_data("t2_data", 1'b0, 8'h0);
    rd_stat("t2_stat_drained", 32'h02);

    // RX overrun
    for (int i = 0; i < 17; i++) rx_push(8'(i));
    rd_stat("t3_stat_ovr", 32'h1E);
    for (int i = 0; i < 16; i++) rd_data("t3_data", 1'b0, 8'h0);
    rd_stat("t3_stat_after", exp_status_idle());
    wr(4'h4, 32'h10);
    rx_ovr_m = 1'b0;
    rd_stat("t3_stat_clr", 32'h02);

    // empty read leaves state alone
    rd_data("t5_empty_read", 1'b0, 8'h0);
    rd_stat("t5_stat", 32'h02);

    // push and pop together while full, then while empty
    for (int i = 0; i < 16; i++) rx_push(8'hA0 + 8'(i));
    rd_data("full_pushpop", 1'b1, 8'hEE);
    rd_stat("full_pushpop_stat", 32'h0E);
    for (int i = 0; i < 16; i++) rd_data("full_drain", 1'b0, 8'h0);
    rd_data("empty_pushpop", 1'b1, 8'h77);
    rd_stat("empty_pushpop_stat", 32'h0A);
    rd_data("empty_pushpop_byte", 1'b0, 8'h0);

    // TX overflow with transmitter stalled
    seen_q.delete(); seen_cyc.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) wr(4'h0, 32'h80 + i);
    rd_stat("t4_stat_ovf", 32'h61);
    chk("t4_no_send", seen_q.size(), 0);
    hold_busy = 1'b0;
    wait_seen("t4_count", 16, 16 * 20);
    for (int i = 0; i < 16 && i < seen_q.size(); i++)
      chk("t4_byte", {24'h0, seen_q[i]}, 32'h80 + i);
    repeat (20) @(negedge clk);
    chk("t4_no_extra", seen_q.size(), 16);
    tx_ovf_m = 1'b1;
    rd_stat("t4_stat_after", exp_status_idle());
    wr(4'h4, 32'h20);
    tx_ovf_m = 1'b0;
    rd_stat("t4_stat_clr", 32'h02);

    // interrupt on RX data
    wr(4'h8, 32'h1);
    rx_push(8'h33);
    chk("irq_same_cycle", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
`ifdef UART_BRIDGE_IRQ_EN
    chk("irq_rise", {31'h0, irq}, 32'h1);
`else
    chk("irq_rise", {31'h0, irq}, 32'h0);
`endif
    rd_data("irq_data", 1'b0, 8'h0);
`ifdef UART_BRIDGE_IRQ_EN
    chk("irq_hold", {31'h0, irq}, 32'h1);
`else
    chk("irq_hold", {31'h0, irq}, 32'h0);
`endif
    @(posedge clk); #1;
    chk("irq_fall", {31'h0, irq}, 32'h0);
    wr(4'h8, 32'h0);

    // randomized RX traffic
    for (int n = 0; n < 80; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 5) rx_push(8'($urandom));
      else if (op < 7) rd_data("rnd_rx_data", 1'b0, 8'h0);
      else if (op == 7) rd_data("rnd_rx_pushpop", 1'b1, 8'($urandom));
      else if (op == 8) rd_stat("rnd_rx_stat", exp_status_idle());
      else begin
        wr(4'h4, 32'h10);
        rx_ovr_m = 1'b0;
      end
    end
    while (rx_m.size() > 0) rd_data("rnd_rx_drain", 1'b0, 8'h0);
    rd_stat("rnd_rx_final", exp_status_idle());

    // randomized TX bursts
    for (int b = 0; b < 3; b++) begin
      int n;
      n = $urandom_range(1, 16);
      seen_q.delete(); seen_cyc.delete(); tx_exp.delete();
      for (int i = 0; i < n; i++) begin
        logic [7:0] d;
        d = 8'($urandom);
        tx_exp.push_back(d);
        wr(4'h0, {$urandom, d} >> 0);
      end
      wait_seen("rnd_tx_count", n, n * 20 + 50);
      for (int i = 0; i < n && i < seen_q.size(); i++)
        chk("rnd_tx_byte", {24'h0, seen_q[i]}, {24'h0, tx_exp[i]});
      repeat (20) @(negedge clk);
      rd_stat("rnd_tx_stat", exp_status_idle());
    end

    chk("single_cycle_flag", double_pulse, 0);
    chk("irq_never_high", irq_bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, got %0d/%0d", passed, total);
    $fatal(1);
  end

endmodule
